// File: rtl/rx_frame_filter.sv
// rx_frame_filter: classifies each received frame (OK / CRC error / address
// miss / overflow), buffers accepted frames in a DEPTH-entry FIFO drained by a
// valid/ready handshake, and drives pulse-stretched status indicators.
// Optional feature macro: RX_STATS_EN adds saturating per-class event counters
// (cnt_ok, cnt_crc, cnt_id, cnt_ovf) with a synchronous stats_clr input.
module rx_frame_filter #(
  parameter int               ID_W      = 2,
  parameter int               PAYLOAD_W = 128,
  parameter int               DEPTH     = 4,
  parameter logic [ID_W-1:0]  BCAST_ID  = {ID_W{1'b1}},
  parameter int               STRETCH   = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_W-1:0]         my_id,
  input  logic                    in_valid,
  input  logic                    in_crc_err,
  input  logic [ID_W-1:0]         in_dest,
  input  logic [ID_W-1:0]         in_src,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_dest,
  output logic [ID_W-1:0]         out_src,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic [$clog2(DEPTH):0]  fifo_count,
`ifdef RX_STATS_EN
  input  logic                    stats_clr,
  output logic [15:0]             cnt_ok,
  output logic [15:0]             cnt_crc,
  output logic [15:0]             cnt_id,
  output logic [15:0]             cnt_ovf,
`endif
  output logic                    ind_ok,
  output logic                    ind_crc,
  output logic                    ind_id,
  output logic                    ind_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = 2 * ID_W + PAYLOAD_W;
  localparam int TW = $clog2(STRETCH + 1);

  // Event vector bit positions, shared by indicators and counters.
  localparam int EV_OK  = 0;
  localparam int EV_CRC = 1;
  localparam int EV_ID  = 2;
  localparam int EV_OVF = 3;

  // Frame storage; written only, never reset, so it maps onto RAM.
  logic [FW-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [FW-1:0] r_head;

  logic          w_pop;
  logic          w_full;
  logic          w_crc;
  logic          w_miss;
  logic          w_admit;
  logic          w_ovf;
  logic          w_push;
  logic [FW-1:0] w_frame;
  logic [AW-1:0] w_rd_ptr_next;
  logic [CW-1:0] w_count_next;
  logic [FW-1:0] w_head_next;
  logic [3:0]    w_evt;
  logic [3:0]    w_ind;

  // Classification: CRC beats address, address beats overflow. A pop in the
  // same cycle frees a slot, so a full FIFO still accepts the frame.
  assign w_pop   = r_out_valid & out_ready;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_crc   = in_valid & in_crc_err;
  assign w_miss  = in_valid & ~in_crc_err & (in_dest != my_id) & (in_dest != BCAST_ID);
  assign w_admit = in_valid & ~in_crc_err & ~w_miss;
  assign w_ovf   = w_admit & w_full & ~w_pop;
  assign w_push  = w_admit & ~w_ovf;
  assign w_frame = {in_dest, in_src, in_payload};

  assign w_evt[EV_OK]  = w_push;
  assign w_evt[EV_CRC] = w_crc;
  assign w_evt[EV_ID]  = w_miss;
  assign w_evt[EV_OVF] = w_ovf;

  assign w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Next head: the frame being written becomes the head when it lands in the
  // slot the read pointer will point at (empty FIFO, or last entry popped).
  always_comb begin
    w_head_next = r_mem[w_rd_ptr_next];
    if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
      w_head_next = w_frame;
    end
  end

  // Write accepted frames into the storage array.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_frame;
    end
  end

  // FIFO pointers, occupancy and the registered head-of-queue outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      // Data holds its last value once the FIFO drains.
      if (w_count_next != '0) begin
        r_head <= w_head_next;
      end
    end
  end

  assign out_valid                         = r_out_valid;
  assign {out_dest, out_src, out_payload}  = r_head;
  assign fifo_count                        = r_count;

  // One retriggerable stretch timer per event class. The indicator is high in
  // the cycle after a load and while the timer is still counting down, which
  // gives exactly STRETCH high cycles for an isolated event.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stretch
      logic [TW-1:0] r_timer;
      logic          r_ind;

      // Load on event, otherwise count down to zero.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_timer <= '0;
          r_ind   <= 1'b0;
        end else if (w_evt[gi]) begin
          r_timer <= TW'(STRETCH - 1);
          r_ind   <= 1'b1;
        end else begin
          r_ind <= (r_timer != '0);
          if (r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
          end
        end
      end

      assign w_ind[gi] = r_ind;
    end
  endgenerate

  assign ind_ok  = w_ind[EV_OK];
  assign ind_crc = w_ind[EV_CRC];
  assign ind_id  = w_ind[EV_ID];
  assign ind_ovf = w_ind[EV_OVF];

`ifdef RX_STATS_EN
  logic [15:0] w_cnt [4];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_stats
      logic [15:0] r_cnt;

      // Saturating event counter; clear takes precedence over a same-cycle event.
      always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
          r_cnt <= '0;
        end else if (w_evt[gi] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign cnt_ok  = w_cnt[EV_OK];
  assign cnt_crc = w_cnt[EV_CRC];
  assign cnt_id  = w_cnt[EV_ID];
  assign cnt_ovf = w_cnt[EV_OVF];
`else
  // Without the statistics option the event vector only feeds the indicators.
`endif

endmodule
